// File: rtl/pilha_ula_seq.sv
// pilha_ula_seq: parametrised LIFO operand stack feeding a two-operand ALU.
// A single exec request pops B then A, computes f(A,B) and pushes the result.
module pilha_ula_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned OPW   = 5,
    parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             exec,
    input  logic [OPW-1:0]   opcode,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic             full,
    output logic [CNTW-1:0]  count,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] tmp1,
    output logic [WIDTH-1:0] tmp2,
    output logic [WIDTH-1:0] s_ula,
    output logic             carryout,
    output logic             err_underflow,
    output logic             err_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_NAND = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_B,
        S_POP_A,
        S_CALC,
        S_PUSH_R
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] tmp1_q, tmp1_d;
    logic [WIDTH-1:0] tmp2_q, tmp2_d;
    logic [WIDTH-1:0] s_ula_q, s_ula_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             err_un_q, err_un_d;
    logic             err_ov_q, err_ov_d;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] alu_s;
    logic             alu_c;
    logic [WIDTH:0]   sum_w;

    assign top_idx  = AW'(count_q - CNTW'(1));
    assign push_idx = AW'(count_q);
    assign top_val  = (count_q == '0) ? '0 : stack_q[top_idx];

    // ALU on the operand registers; only consumed in CALC
    always_comb begin
        alu_s = tmp1_q;
        alu_c = 1'b0;
        sum_w = {1'b0, tmp1_q} + {1'b0, tmp2_q};
        case (op_q)
            OP_ADD:  begin alu_s = sum_w[WIDTH-1:0]; alu_c = sum_w[WIDTH]; end
            OP_SUB:  begin alu_s = tmp1_q - tmp2_q;  alu_c = (tmp1_q < tmp2_q); end
            OP_AND:  alu_s = tmp1_q & tmp2_q;
            OP_OR:   alu_s = tmp1_q | tmp2_q;
            OP_XOR:  alu_s = tmp1_q ^ tmp2_q;
            OP_NAND: alu_s = ~(tmp1_q & tmp2_q);
            OP_SHL:  begin alu_s = {tmp1_q[WIDTH-2:0], 1'b0}; alu_c = tmp1_q[WIDTH-1]; end
            OP_SHR:  begin alu_s = {1'b0, tmp1_q[WIDTH-1:1]}; alu_c = tmp1_q[0]; end
            default: begin alu_s = tmp1_q; alu_c = 1'b0; end
        endcase
    end

    // Next-state, stack update and registered-output logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        tmp1_d   = tmp1_q;
        tmp2_d   = tmp2_q;
        s_ula_d  = s_ula_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        err_un_d = err_un_q;
        err_ov_d = err_ov_q;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;

        case (state_q)
            S_IDLE: begin
                if (exec) begin
                    if (count_q >= CNTW'(2)) begin
                        op_d    = opcode;
                        state_d = S_POP_B;
                    end else begin
                        err_un_d = 1'b1;
                    end
                end else if (push && pop) begin
                    // replace top; on an empty stack this degenerates to a push
                    we    = 1'b1;
                    wdata = din;
                    if (count_q != '0) begin
                        waddr = top_idx;
                    end else begin
                        waddr   = push_idx;
                        count_d = count_q + CNTW'(1);
                    end
                end else if (push) begin
                    if (count_q == CNTW'(DEPTH)) begin
                        err_ov_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        waddr   = push_idx;
                        wdata   = din;
                        count_d = count_q + CNTW'(1);
                    end
                end else if (pop) begin
                    if (count_q == '0) begin
                        err_un_d = 1'b1;
                    end else begin
                        count_d = count_q - CNTW'(1);
                    end
                end
            end
            S_POP_B: begin
                tmp2_d  = top_val;
                count_d = count_q - CNTW'(1);
                state_d = S_POP_A;
            end
            S_POP_A: begin
                tmp1_d  = top_val;
                count_d = count_q - CNTW'(1);
                state_d = S_CALC;
            end
            S_CALC: begin
                s_ula_d = alu_s;
                carry_d = alu_c;
                state_d = S_PUSH_R;
            end
            S_PUSH_R: begin
                // two entries were freed, so this push cannot overflow
                we      = 1'b1;
                waddr   = push_idx;
                wdata   = s_ula_q;
                count_d = count_q + CNTW'(1);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        empty_d = (count_d == '0);
        full_d  = (count_d == CNTW'(DEPTH));
    end

    // Control and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            tmp1_q   <= '0;
            tmp2_q   <= '0;
            s_ula_q  <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            err_un_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            tmp1_q   <= tmp1_d;
            tmp2_q   <= tmp2_d;
            s_ula_q  <= s_ula_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            err_un_q <= err_un_d;
            err_ov_q <= err_ov_d;
        end
    end

    // Stack storage; contents are not reset
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            stack_q[waddr] <= wdata;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign empty         = empty_q;
    assign full          = full_q;
    assign count         = count_q;
    assign top           = top_val;
    assign tmp1          = tmp1_q;
    assign tmp2          = tmp2_q;
    assign s_ula         = s_ula_q;
    assign carryout      = carry_q;
    assign err_underflow = err_un_q;
    assign err_overflow  = err_ov_q;

endmodule

// File: tb/tb_pilha_ula_seq.sv
// Self-checking bench for pilha_ula_seq: directed scenarios plus random
// push/pop/exec traffic against a queue-based reference model.
module tb_pilha_ula_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned OPW   = 5;
    localparam int unsigned CNTW  = $clog2(DEPTH + 1);
    localparam int          MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             exec = 1'b0;
    logic [OPW-1:0]   opcode = '0;
    logic             busy, done, empty, full, carryout;
    logic             err_underflow, err_overflow;
    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] top, tmp1, tmp2, s_ula;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int q[$];
    bit m_eu, m_eo, m_c;
    int m_t1, m_t2, m_s;

    pilha_ula_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
        .exec(exec), .opcode(opcode), .busy(busy), .done(done),
        .empty(empty), .full(full), .count(count), .top(top),
        .tmp1(tmp1), .tmp2(tmp2), .s_ula(s_ula), .carryout(carryout),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_top();
        return (q.size() == 0) ? 0 : q[$];
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".count"}, int'(count), q.size());
        chk({tag, ".top"}, int'(top), m_top());
        chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
        chk({tag, ".full"}, int'(full), int'(q.size() == DEPTH));
        chk({tag, ".eu"}, int'(err_underflow), int'(m_eu));
        chk({tag, ".eo"}, int'(err_overflow), int'(m_eo));
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".tmp1"}, int'(tmp1), m_t1);
        chk({tag, ".tmp2"}, int'(tmp2), m_t2);
        chk({tag, ".s"}, int'(s_ula), m_s);
        chk({tag, ".c"}, int'(carryout), int'(m_c));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        m_eu = 0; m_eo = 0; m_c = 0; m_t1 = 0; m_t2 = 0; m_s = 0;
        check_state("reset");
        chk("reset.done", int'(done), 0);
    endtask

    task automatic do_push(input int d);
        push = 1'b1; din = WIDTH'(d);
        step();
        push = 1'b0;
        if (q.size() == DEPTH) m_eo = 1;
        else q.push_back(d);
        check_state("push");
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
        if (q.size() == 0) m_eu = 1;
        else void'(q.pop_back());
        check_state("pop");
    endtask

    task automatic do_pushpop(input int d);
        push = 1'b1; pop = 1'b1; din = WIDTH'(d);
        step();
        push = 1'b0; pop = 1'b0;
        if (q.size() > 0) q[q.size()-1] = d;
        else q.push_back(d);
        check_state("pushpop");
    endtask

    // ALU rules in plain integer arithmetic
    task automatic ref_alu(input int op, input int a, input int b, output int s, output bit c);
        c = 0;
        case (op)
            0: begin s = (a + b) % MOD; c = (a + b) >= MOD; end
            1: begin s = (a - b + MOD) % MOD; c = a < b; end
            2: s = a & b;
            3: s = a | b;
            4: s = a ^ b;
            5: s = (~(a & b)) & (MOD - 1);
            6: begin s = (a * 2) % MOD; c = bit'((a >> (WIDTH - 1)) & 1); end
            7: begin s = a / 2; c = bit'(a % 2); end
            default: s = a;
        endcase
    endtask

    task automatic do_exec(input int op, input bit noisy);
        int a, b, s;
        bit c;
        exec = 1'b1; opcode = OPW'(op);
        step();
        exec = 1'b0;
        if (q.size() < 2) begin
            m_eu = 1;
            check_state("exec_rej");
            return;
        end
        b = q.pop_back();
        a = q.pop_back();
        ref_alu(op, a, b, s, c);
        chk("exec.busy0", int'(busy), 1);
        for (int i = 1; i <= 4; i++) begin
            if (noisy) begin
                push = 1'b1;
                pop = 1'($urandom_range(0, 1));
                exec = 1'($urandom_range(0, 1));
                opcode = OPW'($urandom_range(0, 31));
                din = WIDTH'($urandom);
            end
            step();
            push = 1'b0; pop = 1'b0; exec = 1'b0;
            if (i == 1) chk("exec.tmp2", int'(tmp2), b);
            if (i == 2) chk("exec.tmp1", int'(tmp1), a);
            if (i == 3) chk("exec.s_early", int'(s_ula), s);
            if (i < 4) begin
                chk("exec.busy", int'(busy), 1);
                chk("exec.nodone", int'(done), 0);
            end
        end
        chk("exec.done", int'(done), 1);
        q.push_back(s);
        m_t1 = a; m_t2 = b; m_s = s; m_c = c;
        check_state("exec");
        step();
        chk("exec.done_pulse", int'(done), 0);
    endtask

    initial begin
        step();
        // 1: basic add
        do_reset();
        do_push(12); do_push(15);
        do_exec(0, 0);
        chk("t1.s", int'(s_ula), 27);
        chk("t1.top", int'(top), 27);

        // 2: subtract with borrow, add with carry
        do_reset();
        do_push(12); do_push(15);
        do_exec(1, 0);
        chk("t2.sub", int'(s_ula), 253);
        chk("t2.borrow", int'(carryout), 1);
        do_push(200); do_push(100);
        do_exec(0, 0);
        chk("t2.add", int'(s_ula), 44);
        chk("t2.carry", int'(carryout), 1);

        // 3: exec underflow on a single entry, cleared by reset
        do_reset();
        do_push(5);
        do_exec(0, 0);
        chk("t3.eu", int'(err_underflow), 1);
        do_reset();

        // 4: fill, overflow, replace top while full
        for (int i = 1; i <= DEPTH; i++) do_push(i);
        do_push(99);
        chk("t4.top", int'(top), 16);
        chk("t4.eo", int'(err_overflow), 1);
        do_pushpop(7);
        chk("t4.repl", int'(top), 7);
        do_pop();

        // 5: latched opcode, inputs ignored while busy
        do_reset();
        do_push(12); do_push(15);
        do_exec(4, 1);
        chk("t5.xor", int'(s_ula), 3);
        chk("t5.count", int'(count), 1);

        // 6: reset during CALC leaves no effect
        do_reset();
        do_push(12); do_push(15);
        exec = 1'b1; opcode = '0;
        step();
        exec = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6.count", int'(count), 0);
        chk("t6.s", int'(s_ula), 0);
        chk("t6.busy", int'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            chk("t6.nodone", int'(done), 0);
            step();
        end
        q.delete();
        m_eu = 0; m_eo = 0; m_c = 0; m_t1 = 0; m_t2 = 0; m_s = 0;
        check_state("t6");

        // pop on empty, push+pop on empty
        do_pop();
        chk("edge.eu", int'(err_underflow), 1);
        do_pushpop(42);
        chk("edge.pp_empty", int'(count), 1);

        // random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_push(int'($urandom_range(0, MOD - 1)));
                3:       do_pop();
                4:       do_pushpop(int'($urandom_range(0, MOD - 1)));
                5, 6, 7: do_exec(int'($urandom_range(0, 31)), 0);
                8:       do_exec(int'($urandom_range(0, 7)), 1);
                default: if ($urandom_range(0, 7) == 0) do_reset();
                         else step();
            endcase
        end
        check_state("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
